pipelined_adder_nb: RTL and testbench
=====================================

// Module: pipelined_adder_nb
// PURPOSE
//  Parametrised, pipelined ripple-carry adder/subtractor; next generation of the fixed 8-bit full adder.
//  Splits a WIDTH-bit add into STAGES carry-chained segments, one register stage per segment.
//  Valid/ready handshake with backpressure on both sides; per-transaction add/sub mode.
//  Serves as the sequential golden design for equivalence-checker regression (unrolled vs. ref).
// PARAMETERS
//  WIDTH   8  operand/sum width in bits; WIDTH % STAGES == 0 (elaboration error otherwise)
//  STAGES  2  pipeline depth = number of carry segments; SEG = WIDTH/STAGES bits per segment, STAGES>=1
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand transaction present
//  in_ready   out  1      block accepts transaction this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  cin        in   1      carry-in (ignored when sub=1)
//  sub        in   1      0: A+B+cin; 1: A-B (A + ~B + 1)
//  out_valid  out  1      result present
//  out_ready  in   1      consumer accepts result this cycle
//  sum        out  WIDTH  result bits
//  cout       out  1      carry out of MSB (for sub: 1 = no borrow)
//  ovf        out  1      signed two's-complement overflow = carry into MSB ^ carry out of MSB
// BEHAVIOUR
//  - Reset (async assert, sync deassert by caller): all stage valid bits 0; out_valid=0, sum=0, cout=0, ovf=0;
//    in_ready=1 the first cycle after reset releases. Data registers also cleared to 0.
//  - Global advance: adv = ~out_valid | out_ready; in_ready = adv (combinational, no dependency on in_valid).
//  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
//  - When adv=1 every stage register loads from its predecessor (stage 0 from inputs); valid bits shift too,
//    so bubbles propagate (not collapsed). When adv=0 all stage registers hold.
//  - Stage k (0..STAGES-1) computes sum bits [k*SEG +: SEG] from registered operand slice and carry of stage k-1;
//    stage 0 carry-in = sub ? 1 : cin; B slice is inverted when sub=1 (sub bit travels with the data).
//  - Unprocessed operand slices and already-computed sum slices are skew-registered alongside; output sum
//    is the last stage's assembled word. Latency: exactly STAGES cycles from accept to out_valid with no stall.
//  - Throughput: one transaction/cycle while out_ready=1.
//  - Arithmetic is modulo 2^WIDTH; cout/ovf computed in the final stage from MSB carry-in/carry-out.
//  - Simultaneous accept and drain on a full pipe: allowed, no bubble inserted, no data lost.
//  - out_ready low with out_valid high: sum/cout/ovf/out_valid held stable until accepted.
//  - in_a/in_b/cin/sub sampled only on accept; changes while in_ready=0 have no effect.
//  - Reset mid-operation: all in-flight transactions dropped, no result emitted after reset.
//  - STAGES=1: single register stage, latency 1, equivalent to registered full adder.
// STRUCTURE
//  - Package adder_pkg: localparam MODE_ADD=1'b0, MODE_SUB=1'b1; function for SEG width check.
//  - One sub-module: adder_seg #(SEG) -- combinational ripple chain of full-adder cells
//    (a,b,ci -> s,co, plus carry into MSB for ovf); instantiated STAGES times via generate.
//  - Top holds stage valid regs, skew regs and handshake logic only.
// TESTING
//  - Reset: assert rst mid-stream with 2 in flight -> out_valid=0, sum=0 next edge; no stale result after release.
//  - WIDTH=8,STAGES=2: a=8'hFF,b=8'h01,cin=0,sub=0 -> after 2 cycles sum=8'h00,cout=1,ovf=0.
//  - Sub: a=8'h80,b=8'h01,sub=1 -> sum=8'h7F,cout=1,ovf=1; a=8'h05,b=8'h07,sub=1 -> sum=8'hFE,cout=0,ovf=0.
//  - Streaming: 256 back-to-back random adds, out_ready=1 -> one result per cycle, in order, match A+B+cin.
//  - Backpressure: out_ready=0 for 5 cycles with full pipe -> in_ready=0, outputs held; release -> no loss/dup.
//  - Param sweep (8/1, 16/4, 32/8): exhaustive carry-chain case a=all-ones,b=0,cin=1 -> sum=0,cout=1.

Source files
------------

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared mode encodings and parameter checks for the pipelined adder
package adder_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Segments must be non-empty and tile the word exactly.
    function automatic bit seg_ok(input int width, input int stages);
        return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_seg.sv
// rtl/adder_seg.sv - combinational ripple-carry segment of full-adder cells
module adder_seg #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           cm
);

    logic carry;

    // cm ends up as the carry into the segment MSB, needed for signed overflow.
    always_comb begin
        carry = ci;
        cm    = ci;
        s     = '0;
        for (int i = 0; i < SEG; i++) begin
            cm    = carry;
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        co = carry;
    end

endmodule

// File: rtl/pipelined_adder_nb.sv
// rtl/pipelined_adder_nb.sv - STAGES-deep carry-segmented adder/subtractor with valid/ready flow control
module pipelined_adder_nb
    import adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG = WIDTH / STAGES;

    if (!seg_ok(WIDTH, STAGES)) begin : g_param_check
        $error("pipelined_adder_nb: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    // Stage k register holds segments 0..k of the sum plus the carry leaving segment k.
    logic [STAGES-1:0] v_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] sub_q;
    logic              cout_q;
    logic              ovf_q;

    logic [WIDTH-1:0]  a_in  [STAGES];
    logic [WIDTH-1:0]  b_in  [STAGES];
    logic [WIDTH-1:0]  s_in  [STAGES];
    logic [WIDTH-1:0]  s_nxt [STAGES];
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] sub_in;
    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] c_nxt;
    logic [STAGES-1:0] cm_nxt;

    logic adv;

    assign out_valid = v_q[STAGES-1];
    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG-1:0] seg_s;
        logic [SEG-1:0] seg_b;
        logic           unused_ops;

        if (k == 0) begin : g_first
            assign a_in[k]   = in_a;
            assign b_in[k]   = in_b;
            assign s_in[k]   = '0;
            assign c_in[k]   = (sub == MODE_SUB) ? 1'b1 : cin;
            assign sub_in[k] = sub;
            assign v_in[k]   = in_valid;
        end else begin : g_next
            assign a_in[k]   = a_q[k-1];
            assign b_in[k]   = b_q[k-1];
            assign s_in[k]   = s_q[k-1];
            assign c_in[k]   = c_q[k-1];
            assign sub_in[k] = sub_q[k-1];
            assign v_in[k]   = v_q[k-1];
        end

        assign seg_b = b_in[k][k*SEG +: SEG] ^ {SEG{sub_in[k] == MODE_SUB}};

        adder_seg #(.SEG(SEG)) u_seg (
            .a  (a_in[k][k*SEG +: SEG]),
            .b  (seg_b),
            .ci (c_in[k]),
            .s  (seg_s),
            .co (c_nxt[k]),
            .cm (cm_nxt[k])
        );

        for (genvar j = 0; j < STAGES; j++) begin : g_slice
            assign s_nxt[k][j*SEG +: SEG] = (j == k) ? seg_s : s_in[k][j*SEG +: SEG];
        end

        // Already-consumed operand slices ride along but are never read again.
        assign unused_ops = ^{a_q[k], b_q[k], cm_nxt[k]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= '0;
            c_q    <= '0;
            sub_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (adv) begin
            v_q    <= v_in;
            c_q    <= c_nxt;
            sub_q  <= sub_in;
            cout_q <= c_nxt[STAGES-1];
            ovf_q  <= c_nxt[STAGES-1] ^ cm_nxt[STAGES-1];
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= s_nxt[k];
            end
        end
    end

    assign sum  = s_q[STAGES-1];
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_pipelined_adder_nb.sv
// tb/tb_pipelined_adder_nb.sv - randomized self-checking bench with arithmetic reference model
module tb_pipelined_adder_nb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic       cin = 1'b0;
    logic       sub = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    logic        sw_valid = 1'b0;
    logic        sw_ready = 1'b1;
    logic        sw_cin = 1'b0;
    logic        sw_sub = 1'b0;
    logic [7:0]  a1 = '0, b1 = '0, s1;
    logic [15:0] a4 = '0, b4 = '0, s4;
    logic [31:0] a8 = '0, b8 = '0, s8;
    logic        r1, r4, r8, v1, v4, v8, c1, c4, c8, o1, o4, o8;

    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0] exp_q [$];

    always #5 clk = ~clk;

    pipelined_adder_nb #(.WIDTH(8), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    pipelined_adder_nb #(.WIDTH(8), .STAGES(1)) dut_8_1 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r1),
        .in_a(a1), .in_b(b1), .cin(sw_cin), .sub(sw_sub),
        .out_valid(v1), .out_ready(sw_ready), .sum(s1), .cout(c1), .ovf(o1)
    );

    pipelined_adder_nb #(.WIDTH(16), .STAGES(4)) dut_16_4 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r4),
        .in_a(a4), .in_b(b4), .cin(sw_cin), .sub(sw_sub),
        .out_valid(v4), .out_ready(sw_ready), .sum(s4), .cout(c4), .ovf(o4)
    );

    pipelined_adder_nb #(.WIDTH(32), .STAGES(8)) dut_32_8 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r8),
        .in_a(a8), .in_b(b8), .cin(sw_cin), .sub(sw_sub),
        .out_valid(v8), .out_ready(sw_ready), .sum(s8), .cout(c8), .ovf(o8)
    );

    // Reference: integer arithmetic, returns {ovf, cout, sum}.
    function automatic logic [9:0] ref_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic c, input logic s);
        int sa, sb, sr, full;
        logic [7:0] r;
        sa = (a >= 8'd128) ? int'(a) - 256 : int'(a);
        sb = (b >= 8'd128) ? int'(b) - 256 : int'(b);
        if (s) begin
            full = int'(a) + (255 - int'(b)) + 1;
            sr   = sa - sb;
        end else begin
            full = int'(a) + int'(b) + int'(c);
            sr   = sa + sb + int'(c);
        end
        r = full[7:0];
        return {(sr > 127) || (sr < -128), full > 255, r};
    endfunction

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic s, input logic r);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        cin       = c;
        sub       = s;
        out_ready = r;
    endtask

    task automatic test_reset();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, sum, cout, ovf, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b sum=%h cout=%b ovf=%b in_ready=%b, want 0 00 0 0 1",
                     out_valid, sum, cout, ovf, in_ready);
        end
        @(negedge clk);
        drive(1'b1, 8'h3C, 8'h21, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 8'h11, 8'h22, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_prefill: out_valid=%b, want 1", out_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({out_valid, sum, cout, ovf} !== 11'h0) begin
            n_fail++;
            $display("FAIL reset_async: got v=%b sum=%h cout=%b ovf=%b, want all 0", out_valid, sum, cout, ovf);
        end
        @(negedge clk);
        n_tests++;
        if ({out_valid, sum} !== 9'h0) begin
            n_fail++;
            $display("FAIL reset_edge: got v=%b sum=%h, want 0 00", out_valid, sum);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_stale cycle %0d: out_valid=%b, want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_directed();
        logic [7:0] ta [3] = '{8'hFF, 8'h80, 8'h05};
        logic [7:0] tb [3] = '{8'h01, 8'h01, 8'h07};
        logic       ts [3] = '{1'b0, 1'b1, 1'b1};
        logic [9:0] te [3] = '{{1'b0, 1'b1, 8'h00}, {1'b1, 1'b1, 8'h7F}, {1'b0, 1'b0, 8'hFE}};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, ta[i], tb[i], 1'b0, ts[i], 1'b1);
            @(negedge clk);
            drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_early %0d: out_valid=%b after 1 cycle, want 0", i, out_valid);
            end
            @(negedge clk);
            n_tests++;
            if ({out_valid, ovf, cout, sum} !== {1'b1, te[i]}) begin
                n_fail++;
                $display("FAIL directed_result %0d: got v=%b ovf=%b cout=%b sum=%h, want v=1 ovf=%b cout=%b sum=%h",
                         i, out_valid, ovf, cout, sum, te[i][9], te[i][8], te[i][7:0]);
            end
        end
    endtask

    // One cycle of scoreboarded traffic: transfers are decided on values that will be present at the next edge.
    task automatic sb_cycle(input logic v, input logic r, input logic allow_sub, output int got);
        logic [7:0] a, b;
        logic c, s;
        got = 0;
        a = 8'($urandom);
        b = 8'($urandom);
        c = 1'($urandom);
        s = allow_sub ? 1'($urandom) : 1'b0;
        drive(v, a, b, c, s, r);
        #1;
        if (out_valid && out_ready) begin
            got = 1;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_spurious: result sum=%h with nothing outstanding", sum);
            end else if ({ovf, cout, sum} !== exp_q[0]) begin
                n_fail++;
                $display("FAIL sb_data: got ovf=%b cout=%b sum=%h, want ovf=%b cout=%b sum=%h",
                         ovf, cout, sum, exp_q[0][9], exp_q[0][8], exp_q[0][7:0]);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        if (in_valid && in_ready) exp_q.push_back(ref_model(a, b, c, s));
    endtask

    task automatic test_back_to_back();
        int got, n_got, first, last;
        n_got = 0;
        first = -1;
        last  = -1;
        exp_q.delete();
        for (int cyc = 0; cyc < 300 && n_got < 256; cyc++) begin
            @(negedge clk);
            sb_cycle(cyc < 256, 1'b1, 1'b0, got);
            if (got != 0) begin
                if (first < 0) first = cyc;
                last = cyc;
                n_got++;
            end
        end
        n_tests++;
        if (n_got != 256 || last - first != 255 || first != 2) begin
            n_fail++;
            $display("FAIL b2b_rate: got %0d results over cycles %0d..%0d, want 256 over 2..257",
                     n_got, first, last);
        end
    endtask

    task automatic test_random_handshake();
        int got;
        exp_q.delete();
        for (int cyc = 0; cyc < 320; cyc++) begin
            @(negedge clk);
            if (cyc < 300) sb_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, 1'b1, got);
            else           sb_cycle(1'b0, 1'b1, 1'b1, got);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: %0d results never delivered, want 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int got, n_in, n_out;
        logic [10:0] snap;
        exp_q.delete();
        n_in = 0;
        for (int cyc = 0; cyc < 10 && in_ready !== 1'b0; cyc++) begin
            @(negedge clk);
            sb_cycle(1'b1, 1'b0, 1'b1, got);
            if (in_valid && in_ready) n_in++;
        end
        @(negedge clk);
        snap = {out_valid, ovf, cout, sum};
        for (int i = 0; i < 5; i++) begin
            sb_cycle(1'b1, 1'b0, 1'b1, got);
            n_tests++;
            if (in_ready !== 1'b0 || {out_valid, ovf, cout, sum} !== snap) begin
                n_fail++;
                $display("FAIL bp_hold %0d: in_ready=%b out=%h, want in_ready=0 out=%h",
                         i, in_ready, {out_valid, ovf, cout, sum}, snap);
            end
            @(negedge clk);
        end
        n_tests++;
        if (n_in != 2 || snap[10] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_fill: accepted %0d with out_valid=%b, want 2 with out_valid=1", n_in, snap[10]);
        end
        n_out = 0;
        for (int i = 0; i < 10; i++) begin
            sb_cycle(1'b0, 1'b1, 1'b1, got);
            n_out += got;
            @(negedge clk);
        end
        n_tests++;
        if (n_out != 2 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_release: delivered %0d, left %0d, want 2 delivered 0 left", n_out, exp_q.size());
        end
    endtask

    task automatic test_param_sweep();
        int l1, l4, l8;
        logic [2:0] ok;
        l1 = -1; l4 = -1; l8 = -1;
        ok = 3'b000;
        @(negedge clk);
        sw_valid = 1'b1;
        sw_ready = 1'b1;
        sw_cin   = 1'b1;
        sw_sub   = 1'b0;
        a1 = '1; b1 = '0;
        a4 = '1; b4 = '0;
        a8 = '1; b8 = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            sw_valid = 1'b0;
            if (v1 === 1'b1 && l1 < 0) begin l1 = c; ok[0] = ({s1, c1, o1} === {8'h0, 1'b1, 1'b0}); end
            if (v4 === 1'b1 && l4 < 0) begin l4 = c; ok[1] = ({s4, c4, o4} === {16'h0, 1'b1, 1'b0}); end
            if (v8 === 1'b1 && l8 < 0) begin l8 = c; ok[2] = ({s8, c8, o8} === {32'h0, 1'b1, 1'b0}); end
        end
        n_tests++;
        if (l1 != 1 || ok[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_8_1: latency %0d sum=%h cout=%b, want latency 1 sum=0 cout=1", l1, s1, c1);
        end
        n_tests++;
        if (l4 != 4 || ok[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_16_4: latency %0d sum=%h cout=%b, want latency 4 sum=0 cout=1", l4, s4, c4);
        end
        n_tests++;
        if (l8 != 8 || ok[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_32_8: latency %0d sum=%h cout=%b, want latency 8 sum=0 cout=1", l8, s8, c8);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random_handshake();
        test_param_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
